// File: rtl/game_pkg.sv
// game_pkg: shared game-logic types and constants.
//   hp_state_t            - per-player health state (ALIVE / INVULN / DEAD)
//   PLAYER_MAX_HP         - default full health for a player
//   GAME_CLK_HZ           - rate of the game-logic clock
//   IFRAME_3S_CYCLES      - 3 seconds of invulnerability expressed in clk cycles
//   IFRAME_CYCLES_DEFAULT - default invulnerability window length
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } hp_state_t;

    localparam int PLAYER_MAX_HP         = 8;
    localparam int GAME_CLK_HZ           = 100;
    localparam int INVULN_SECONDS        = 3;
    localparam int IFRAME_3S_CYCLES      = INVULN_SECONDS * GAME_CLK_HZ;
    localparam int IFRAME_CYCLES_DEFAULT = IFRAME_3S_CYCLES;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: load/decrement down-counter used for invulnerability windows
// and the blink divider.
//   clk, reset - clock, synchronous active-high reset (count cleared to 0)
//   load       - load the counter with CYCLES-1 (wins over dec)
//   dec        - decrement by one, stopping at 0
//   done       - counter currently at 0
module cycle_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    // A single-cycle period still needs one bit of storage.
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/health_tracker.sv
// health_tracker: per-player health register with saturating damage/heal,
// timed invulnerability after a hit or respawn, and death handling.
//   clk, reset - clock, synchronous active-high reset
//   damage     - damage amount; nonzero is a hit request
//   heal       - +1 health request
//   respawn    - leave DEAD (ignored in other states)
//   health     - current health
//   invuln     - high while invulnerable
//   dead       - high while dead
//   hit        - one-cycle pulse per accepted hit
//   blink      - sprite visibility; toggles while invulnerable, else 1
module health_tracker
    import game_pkg::*;
#(
    parameter int MAX_HP        = PLAYER_MAX_HP,
    parameter int HP_W          = 4,
    parameter int DMG_W         = 2,
    parameter int IFRAME_CYCLES = IFRAME_CYCLES_DEFAULT,
    parameter int BLINK_CYCLES  = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DMG_W-1:0] damage,
    input  logic             heal,
    input  logic             respawn,
    output logic [HP_W-1:0]  health,
    output logic             invuln,
    output logic             dead,
    output logic             hit,
    output logic             blink
);

    // One extra bit beyond the wider operand so the difference keeps its sign.
    localparam int SUB_W = ((HP_W > DMG_W) ? HP_W : DMG_W) + 1;
    localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);

    hp_state_t state, next_state;

    logic ifr_done;
    logic blk_done;
    logic in_invuln;
    logic dmg_req;
    logic lethal;
    logic enter_invuln;
    logic blk_load;
    logic [HP_W-1:0] hp_after_dmg;
    logic [HP_W-1:0] hp_after_heal;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [DMG_W-1:0] dmg);
        logic signed [SUB_W-1:0] diff;
        diff = $signed(SUB_W'(hp)) - $signed(SUB_W'(dmg));
        if (diff[SUB_W-1] || (diff == '0)) begin
            return '0;
        end
        return diff[HP_W-1:0];
    endfunction

    function automatic logic [HP_W-1:0] sat_inc(input logic [HP_W-1:0] hp);
        if (hp >= HP_FULL) begin
            return HP_FULL;
        end
        return hp + HP_W'(1);
    endfunction

    assign in_invuln     = (state == INVULN);
    assign dmg_req       = (damage != '0);
    assign hp_after_dmg  = sat_sub(health, damage);
    assign hp_after_heal = sat_inc(health);
    assign lethal        = (hp_after_dmg == '0);
    assign enter_invuln  = ((state == ALIVE) && dmg_req && !lethal) ||
                           ((state == DEAD) && respawn);
    // Blink divider restarts its half-period on entry and each time it expires.
    assign blk_load      = enter_invuln || (in_invuln && blk_done);

    cycle_timer #(.CYCLES(IFRAME_CYCLES)) u_iframe_timer (
        .clk   (clk),
        .reset (reset),
        .load  (enter_invuln),
        .dec   (in_invuln),
        .done  (ifr_done)
    );

    cycle_timer #(.CYCLES(BLINK_CYCLES)) u_blink_timer (
        .clk   (clk),
        .reset (reset),
        .load  (blk_load),
        .dec   (in_invuln),
        .done  (blk_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALIVE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ALIVE: begin
                if (dmg_req) begin
                    next_state = lethal ? DEAD : INVULN;
                end
            end
            INVULN: begin
                if (ifr_done) begin
                    next_state = ALIVE;
                end
            end
            DEAD: begin
                if (respawn) begin
                    next_state = INVULN;
                end
            end
            default: next_state = ALIVE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        invuln = 1'b0;
        dead   = 1'b0;
        unique case (state)
            INVULN:  invuln = 1'b1;
            DEAD:    dead   = 1'b1;
            default: ;
        endcase
    end

    // Health, hit pulse and blink registers
    always_ff @(posedge clk) begin
        if (reset) begin
            health <= HP_FULL;
            hit    <= 1'b0;
            blink  <= 1'b1;
        end else begin
            hit <= 1'b0;
            unique case (state)
                ALIVE: begin
                    // Damage takes precedence; a simultaneous heal is dropped.
                    if (dmg_req) begin
                        health <= hp_after_dmg;
                        hit    <= 1'b1;
                        blink  <= lethal;
                    end else if (heal) begin
                        health <= hp_after_heal;
                    end
                end
                INVULN: begin
                    if (heal) begin
                        health <= hp_after_heal;
                    end
                    if (ifr_done) begin
                        blink <= 1'b1;
                    end else if (blk_done) begin
                        blink <= ~blink;
                    end
                end
                DEAD: begin
                    if (respawn) begin
                        health <= HP_FULL;
                        blink  <= 1'b0;
                    end else begin
                        health <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;

    localparam int MAXHP = 8;
    localparam int IFR   = 10;
    localparam int BLK   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] damage = '0;
    logic       heal = 1'b0;
    logic       respawn = 1'b0;
    logic [3:0] health;
    logic       invuln, dead, hit, blink;

    logic [2:0] damage12 = '0;
    logic       heal12 = 1'b0;
    logic       respawn12 = 1'b0;
    logic [3:0] health12;
    logic       invuln12, dead12, hit12, blink12;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 = alive, 1 = invulnerable, 2 = dead
    int m_hp = MAXHP;
    int m_mode = 0;
    int m_left = 0;
    int m_age = 0;
    int m_hit = 0;

    health_tracker #(.MAX_HP(MAXHP), .HP_W(4), .DMG_W(2),
                     .IFRAME_CYCLES(IFR), .BLINK_CYCLES(BLK)) dut (
        .clk(clk), .reset(reset), .damage(damage), .heal(heal), .respawn(respawn),
        .health(health), .invuln(invuln), .dead(dead), .hit(hit), .blink(blink)
    );

    health_tracker #(.MAX_HP(12), .HP_W(4), .DMG_W(3),
                     .IFRAME_CYCLES(IFR), .BLINK_CYCLES(BLK)) dut12 (
        .clk(clk), .reset(reset), .damage(damage12), .heal(heal12), .respawn(respawn12),
        .health(health12), .invuln(invuln12), .dead(dead12), .hit(hit12), .blink(blink12)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit hl, input bit rs, input bit rst);
        m_hit = 0;
        if (rst) begin
            m_hp = MAXHP; m_mode = 0; m_left = 0; m_age = 0;
        end else if (m_mode == 0) begin
            if (d != 0) begin
                m_hit = 1;
                if (d >= m_hp) begin
                    m_hp = 0; m_mode = 2;
                end else begin
                    m_hp = m_hp - d; m_mode = 1; m_left = IFR; m_age = 0;
                end
            end else if (hl) begin
                m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
            end
        end else if (m_mode == 1) begin
            if (hl) m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
            m_age++;
            m_left--;
            if (m_left == 0) m_mode = 0;
        end else begin
            if (rs) begin
                m_hp = MAXHP; m_mode = 1; m_left = IFR; m_age = 0;
            end
        end
    endtask

    task automatic tick(input int d, input bit hl, input bit rs, input bit rst);
        damage = d[1:0]; heal = hl; respawn = rs; reset = rst;
        @(posedge clk);
        model_step(d, hl, rs, rst);
        #1;
        check("mdl_health", int'(health), m_hp);
        check("mdl_invuln", int'(invuln), (m_mode == 1) ? 1 : 0);
        check("mdl_dead", int'(dead), (m_mode == 2) ? 1 : 0);
        check("mdl_hit", int'(hit), m_hit);
        check("mdl_blink", int'(blink), (m_mode == 1) ? ((m_age / BLK) % 2) : 1);
    endtask

    task automatic wait_alive(input string name);
        for (int i = 0; i < 50; i++) begin
            if (!invuln) break;
            tick(0, 0, 0, 0);
        end
        check(name, int'(invuln), 0);
    endtask

    typedef struct {
        int d;
        bit hl;
        int e_hp;
        bit e_inv;
        bit e_dead;
        bit e_hit;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int hits;
        int cnt;
        int hit_t[$];
        int hit_hp[$];

        tbl[0]  = '{1, 0, 7, 1, 0, 1};
        tbl[1]  = '{2, 0, 7, 1, 0, 0};
        tbl[2]  = '{0, 1, 8, 1, 0, 0};
        tbl[3]  = '{0, 1, 8, 1, 0, 0};
        tbl[4]  = '{0, 0, 8, 1, 0, 0};
        tbl[5]  = '{3, 0, 8, 1, 0, 0};
        tbl[6]  = '{0, 0, 8, 1, 0, 0};
        tbl[7]  = '{0, 0, 8, 1, 0, 0};
        tbl[8]  = '{0, 0, 8, 1, 0, 0};
        tbl[9]  = '{0, 0, 8, 1, 0, 0};
        tbl[10] = '{0, 0, 8, 0, 0, 0};
        tbl[11] = '{3, 1, 5, 1, 0, 1};

        // Reset behaviour
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        check("rst_health", int'(health), 8);
        check("rst_invuln", int'(invuln), 0);
        check("rst_dead", int'(dead), 0);
        check("rst_blink", int'(blink), 1);
        check("rst_hit", int'(hit), 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(2, 0, 0, 1);
        check("rst_inv_health", int'(health), 8);
        check("rst_inv_invuln", int'(invuln), 0);
        check("rst_inv_blink", int'(blink), 1);
        check("rst_inv_hit", int'(hit), 0);

        // Table-driven vectors from a fresh ALIVE state
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].d, tbl[i].hl, 0, 0);
            check("tbl_health", int'(health), tbl[i].e_hp);
            check("tbl_invuln", int'(invuln), int'(tbl[i].e_inv));
            check("tbl_dead", int'(dead), int'(tbl[i].e_dead));
            check("tbl_hit", int'(hit), int'(tbl[i].e_hit));
        end

        // Single hit: window length and blink pattern
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        check("single_health", int'(health), 7);
        check("single_hit", int'(hit), 1);
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            if (j > 0) tick(0, 0, 0, 0);
            if (invuln) cnt++;
            if (j < IFR) check("single_blink", int'(blink), (j % 4 < 2) ? 0 : 1);
        end
        check("single_window", cnt, IFR);

        // Held damage: one hit per window
        tick(0, 0, 0, 1);
        hits = 0;
        for (int k = 0; k < 30; k++) begin
            tick(2, 0, 0, 0);
            if (hit) begin
                hits++;
                hit_t.push_back(k);
                hit_hp.push_back(int'(health));
            end
        end
        check("held_hits", hits, 3);
        if (hit_t.size() == 3) begin
            check("held_t1", hit_t[1] - hit_t[0], IFR + 1);
            check("held_t2", hit_t[2] - hit_t[1], IFR + 1);
            check("held_hp0", hit_hp[0], 6);
            check("held_hp1", hit_hp[1], 4);
            check("held_hp2", hit_hp[2], 2);
        end

        // Lethal hit, dead inputs ignored, respawn
        wait_alive("lethal_wait");
        tick(3, 0, 0, 0);
        check("lethal_health", int'(health), 0);
        check("lethal_dead", int'(dead), 1);
        check("lethal_hit", int'(hit), 1);
        for (int j = 0; j < 3; j++) tick(3, 1, 0, 0);
        check("dead_health", int'(health), 0);
        check("dead_dead", int'(dead), 1);
        check("dead_hit", int'(hit), 0);
        tick(0, 0, 1, 0);
        check("respawn_health", int'(health), 8);
        check("respawn_dead", int'(dead), 0);
        check("respawn_hit", int'(hit), 0);
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            if (j > 0) tick(0, 0, 0, 0);
            if (invuln) cnt++;
        end
        check("respawn_window", cnt, IFR);

        // Healing
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 0);
        check("heal_full", int'(health), 8);
        tick(3, 0, 0, 0);
        check("heal_pre", int'(health), 5);
        tick(0, 1, 0, 0);
        check("heal_invuln", int'(health), 6);
        wait_alive("heal_wait");
        tick(1, 1, 0, 0);
        check("heal_vs_dmg", int'(health), 5);
        check("heal_vs_dmg_hit", int'(hit), 1);

        // Wider parameter set on the second instance
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        check("p12_reset", int'(health12), 12);
        damage12 = 3'd7;
        tick(0, 0, 0, 0);
        damage12 = 3'd0;
        check("p12_health", int'(health12), 5);
        check("p12_hit", int'(hit12), 1);
        check("p12_invuln", int'(invuln12), 1);
        for (int j = 0; j < IFR; j++) tick(0, 0, 0, 0);
        check("p12_alive", int'(invuln12), 0);
        damage12 = 3'd7;
        tick(0, 0, 0, 0);
        damage12 = 3'd0;
        check("p12_lethal", int'(health12), 0);
        check("p12_dead", int'(dead12), 1);

        // Randomised traffic against the reference model
        tick(0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            tick(d, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/health_tracker.md
# health_tracker

Parametrised per-player health register with damage amount, healing, timed invulnerability and death/respawn handling. It sits between the collision/damage logic and the HUD/game-over logic. It replaces the fixed 8-point, 1-damage counter with a cycle-counted invulnerability window, saturating arithmetic and an explicit state machine.

## Interface
Parameters:
- `MAX_HP`, default 8: full health; reset and respawn value.
- `HP_W`, default 4: width of `health`; must satisfy `MAX_HP < 2**HP_W`.
- `DMG_W`, default 2: width of `damage`.
- `IFRAME_CYCLES`, default 300: invulnerability length in clk cycles after a hit or respawn; must be ≥ 2.
- `BLINK_CYCLES`, default 25: half-period of the `blink` output while invulnerable; must be ≥ 1.

Ports:
- `clk` — input, 1 bit: clock.
- `reset` — input, 1 bit: synchronous, active-high.
- `damage` — input, `DMG_W` bits: damage amount; a nonzero value is a hit request, sampled every cycle.
- `heal` — input, 1 bit: +1 health request, sampled every cycle.
- `respawn` — input, 1 bit: leave DEAD; honoured only in DEAD.
- `health` — output, `HP_W` bits: current health.
- `invuln` — output, 1 bit: high while in INVULN.
- `dead` — output, 1 bit: high while in DEAD.
- `hit` — output, 1 bit: one-cycle pulse for each accepted hit.
- `blink` — output, 1 bit: sprite-visibility toggle; constant 1 outside INVULN.

## Operation
- States:
  - ALIVE: accepts damage and heal.
  - INVULN: ignores damage, accepts heal.
  - DEAD: ignores damage and heal.
- ALIVE with `damage != 0`:
  - `health <= health - damage`, saturating at 0.
  - `hit` pulses.
  - Result 0 → DEAD. Otherwise → INVULN, with the timer loaded to `IFRAME_CYCLES-1`.
- ALIVE with `damage == 0` and `heal`: `health <= min(health+1, MAX_HP)`.
- ALIVE with damage and heal in the same cycle: damage wins and the heal is dropped.
- INVULN:
  - Timer decrements each cycle.
  - `heal` works as in ALIVE, saturating at `MAX_HP`.
  - `damage` is discarded; no `hit` pulse.
  - Timer == 0 → ALIVE on the next edge.
- DEAD:
  - `health` holds 0.
  - `respawn` → `health <= MAX_HP`, state INVULN, timer loaded to `IFRAME_CYCLES-1` (spawn protection). No `hit` pulse.
- `blink`:
  - Toggles every `BLINK_CYCLES` cycles of INVULN, starting at 0 on INVULN entry.
  - Forced to 1 in ALIVE and DEAD.
- Arithmetic: compute the subtraction at `HP_W+1` bits, then clamp to 0. Damage ≥ health is lethal.
- Reset, including mid-INVULN or in DEAD:
  - `health = MAX_HP`, state ALIVE, timer 0, blink counter 0.
  - `invuln = 0`, `dead = 0`, `hit = 0`, `blink = 1`.

## Timing
- All outputs are registered.
- Response latency is 1 cycle. Damage sampled at edge N gives the new `health`, the `hit` pulse, and `invuln` or `dead` after edge N.
- `invuln` is high for exactly `IFRAME_CYCLES` consecutive cycles per hit or respawn.
- A hit in the first cycle after `invuln` falls is accepted.
- `damage` held constant is accepted once per invulnerability window, giving a periodic hit every `IFRAME_CYCLES+1` cycles.
- `reset` takes priority over every other input in the same cycle.

## Structure
- Shared `game_pkg`:
  - state enum `hp_state_t` {ALIVE, INVULN, DEAD};
  - default constants `PLAYER_MAX_HP = 8` and `IFRAME_CYCLES_DEFAULT`;
  - the clk-rate-derived cycle count for 3 s.
- One sub-module, `cycle_timer`:
  - load/decrement down-counter, width `$clog2(IFRAME_CYCLES)`;
  - outputs a `done` flag;
  - reused for the blink divider with `BLINK_CYCLES`.

## Test plan
All scenarios use `MAX_HP=8`, `IFRAME_CYCLES=10`, `BLINK_CYCLES=2` unless stated.
- **Reset:** release reset → `health=8`, `invuln=0`, `dead=0`, `blink=1`. Assert reset during INVULN → same values the next cycle.
- **Single hit and window:** `damage=1` for 1 cycle → `health=7`, one `hit` pulse, `invuln` high for exactly 10 cycles, `blink` pattern 0,0,1,1,0,…
- **Held damage:** `damage=2` held for 30 cycles → health 8→6→4→2, hits spaced 11 cycles apart, `damage` ignored during every window.
- **Lethal and respawn:**
  - `health=2`, `damage=3` → `health=0` (saturated), `dead=1`.
  - Damage and heal in DEAD → no change.
  - `respawn` → `health=8`, `invuln=1` for 10 cycles.
- **Heal:**
  - `heal` at `health=8` → stays 8.
  - `heal` during INVULN at 5 → 6.
  - `damage=1` and `heal` together at 6 in ALIVE → 5.
- **Parameters:** `MAX_HP=12`, `HP_W=4`, `DMG_W=3`, `damage=7` at 12 → 5; then `damage=7` at ALIVE → 0, DEAD.
